stopwatch_bcd: RTL and testbench
================================

STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 Parameter: none; all widths and limits fixed.
REQ-002 CLK  input  1  system clock, 50 MHz, all state on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 EN10MS  input  1  one-CLK-wide 100 Hz tick from the 10 ms enable generator.
REQ-005 STARTSTOP  input  1  debounced start/stop button level, CLK-synchronous.
REQ-006 CLR  input  1  debounced clear button level, CLK-synchronous.
REQ-007 LAP  input  1  debounced lap button level; present only with LAP_EN.
REQ-008 CS1, CS10  output  4 each  BCD hundredths/tenths of second.
REQ-009 SEC1, SEC10  output  4 each  BCD seconds units (0-9), tens (0-5).
REQ-010 MIN1, MIN10  output  4 each  BCD minutes units (0-9), tens (0-5).
REQ-011 RUNNING  output  1  high while state is RUN.
REQ-012 OVF  output  1  sticky wrap flag.
REQ-013 LAPHOLD  output  1  high while display frozen; present only with LAP_EN.

Function
REQ-014 STARTSTOP, CLR, LAP each registered once; event = current high AND previous low (rising edge), one cycle wide.
REQ-015 States IDLE, RUN, PAUSE; RUNNING = (state == RUN).
REQ-016 IDLE + start edge -> RUN; RUN + start edge -> PAUSE; PAUSE + start edge -> RUN.
REQ-017 CLR edge in IDLE or PAUSE -> IDLE, all digits 0, OVF 0; CLR edge in RUN ignored.
REQ-018 CLR edge and start edge same cycle in PAUSE: CLR wins, next state IDLE.
REQ-019 Count advances by 0.01 s only on cycles where state == RUN and EN10MS == 1; digits show new value the following cycle.
REQ-020 Cascade: CS1 9->0 carries CS10; CS10 9->0 carries SEC1; SEC1 9->0 carries SEC10; SEC10 5->0 carries MIN1; MIN1 9->0 carries MIN10; MIN10 5->0 is wrap.
REQ-021 Tick at 59:59.99 -> all digits 00:00.00, OVF set, counting continues in RUN.
REQ-022 OVF cleared only by CLR edge (in IDLE/PAUSE) or reset.
REQ-023 Start edge and EN10MS same cycle in RUN: tick counted, then PAUSE.
REQ-024 Start edge and EN10MS same cycle in PAUSE: tick not counted, then RUN.
REQ-025 EN10MS ignored in IDLE and PAUSE; digits hold.
REQ-026 No digit ever holds a non-BCD value or exceeds its stated maximum.

Reset
REQ-027 RST high: state IDLE, all digits 0, RUNNING 0, OVF 0, LAPHOLD 0, edge-detect registers 0, asynchronously.
REQ-028 RST asserted mid-RUN: count lost, no partial tick; after release, first start edge needed to count.
REQ-029 Button held high across RST release produces no edge event.

Configuration
REQ-030 Macro STOPWATCH_LAP_EN: defined -> LAP and LAPHOLD ports present and lap feature active; undefined -> ports absent, outputs always show live count.
REQ-031 With macro: LAP edge in RUN while LAPHOLD 0 -> capture live digits, LAPHOLD 1; outputs show captured value while internal count keeps advancing.
REQ-032 With macro: LAP edge while LAPHOLD 1 (any state), or CLR edge accepted, or RST -> LAPHOLD 0, outputs show live count next cycle.
REQ-033 With macro: LAP edge in IDLE or PAUSE while LAPHOLD 0 ignored.

Verification
REQ-034 Reset, start edge, 150 EN10MS pulses -> digits 00:01.50, RUNNING 1.
REQ-035 Start edge after 37 ticks, 10 more ticks, start edge, 5 ticks -> PAUSE shows 00:00.47, resume adds 5 -> 00:00.52.
REQ-036 Preload by 359999 ticks to 59:59.99, one tick -> 00:00.00, OVF 1; start edge, CLR edge -> IDLE, OVF 0.
REQ-037 Start edge coincident with EN10MS in RUN at 00:00.09 -> 00:00.10 and PAUSE; in PAUSE coincident -> value unchanged, RUN.
REQ-038 CLR edge in RUN at 00:02.00 -> no change, still RUN; RST pulse mid-RUN -> all outputs 0 immediately, state IDLE.
REQ-039 STOPWATCH_LAP_EN defined: LAP edge at 00:03.00, 200 ticks -> outputs 00:03.00, LAPHOLD 1; LAP edge -> 00:05.00, LAPHOLD 0.

Source files
------------

// File: rtl/stopwatch_bcd.sv
// BCD stopwatch mm:ss.cc with IDLE/RUN/PAUSE control; count advances one cycle after each accepted EN10MS.
// Optional lap freeze when STOPWATCH_LAP_EN is defined (adds LAP input and LAPHOLD output).
module stopwatch_bcd (
   input  logic       CLK,
   input  logic       RST,
   input  logic       EN10MS,
   input  logic       STARTSTOP,
   input  logic       CLR,
`ifdef STOPWATCH_LAP_EN
   input  logic       LAP,
   output logic       LAPHOLD,
`endif
   output logic [3:0] CS1,
   output logic [3:0] CS10,
   output logic [3:0] SEC1,
   output logic [3:0] SEC10,
   output logic [3:0] MIN1,
   output logic [3:0] MIN10,
   output logic       RUNNING,
   output logic       OVF
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   state_t     state;
   logic       running;
   logic       ovf;
   logic       ss_q, clr_q, armed;
   logic [3:0] cs1, cs10, sec1, sec10, min1, min10;
   logic       ss_ev, clr_ev, clr_ok, tick;
   logic       c0, c1, c2, c3, c4, c5;
   logic [23:0] live, shown;

   function automatic logic [3:0] bump(input logic [3:0] d, input logic [3:0] maxv);
      return (d >= maxv) ? 4'd0 : d + 4'd1;
   endfunction

   // armed masks the first cycle after reset so a button held through release is not an edge
   assign ss_ev  = armed & STARTSTOP & ~ss_q;
   assign clr_ev = armed & CLR & ~clr_q;
   assign clr_ok = clr_ev & (state != RUN);
   assign tick   = (state == RUN) & EN10MS;

   assign c0 = tick & (cs1 == 4'd9);
   assign c1 = c0 & (cs10 == 4'd9);
   assign c2 = c1 & (sec1 == 4'd9);
   assign c3 = c2 & (sec10 == 4'd5);
   assign c4 = c3 & (min1 == 4'd9);
   assign c5 = c4 & (min10 == 4'd5);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= IDLE;
         running <= 1'b0;
         ovf     <= 1'b0;
         ss_q    <= 1'b0;
         clr_q   <= 1'b0;
         armed   <= 1'b0;
         cs1     <= 4'd0;
         cs10    <= 4'd0;
         sec1    <= 4'd0;
         sec10   <= 4'd0;
         min1    <= 4'd0;
         min10   <= 4'd0;
      end else begin
         ss_q  <= STARTSTOP;
         clr_q <= CLR;
         armed <= 1'b1;
         if (clr_ok) begin
            state   <= IDLE;
            running <= 1'b0;
            ovf     <= 1'b0;
            cs1     <= 4'd0;
            cs10    <= 4'd0;
            sec1    <= 4'd0;
            sec10   <= 4'd0;
            min1    <= 4'd0;
            min10   <= 4'd0;
         end else begin
            case (state)
               IDLE: if (ss_ev) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
               RUN: if (ss_ev) begin
                  state   <= PAUSE;
                  running <= 1'b0;
               end
               PAUSE: if (ss_ev) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
               default: begin
                  state   <= IDLE;
                  running <= 1'b0;
               end
            endcase
            if (tick) cs1   <= bump(cs1, 4'd9);
            if (c0)   cs10  <= bump(cs10, 4'd9);
            if (c1)   sec1  <= bump(sec1, 4'd9);
            if (c2)   sec10 <= bump(sec10, 4'd5);
            if (c3)   min1  <= bump(min1, 4'd9);
            if (c4)   min10 <= bump(min10, 4'd5);
            if (c5)   ovf   <= 1'b1;
         end
      end
   end

   assign live = {min10, min1, sec10, sec1, cs10, cs1};

`ifdef STOPWATCH_LAP_EN
   logic        lap_q, hold;
   logic [23:0] cap;
   logic        lap_ev;

   assign lap_ev = armed & LAP & ~lap_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         lap_q <= 1'b0;
         hold  <= 1'b0;
         cap   <= 24'd0;
      end else begin
         lap_q <= LAP;
         if (clr_ok || (lap_ev && hold)) begin
            hold <= 1'b0;
         end else if (lap_ev && state == RUN) begin
            hold <= 1'b1;
            cap  <= live;
         end
      end
   end

   assign shown   = hold ? cap : live;
   assign LAPHOLD = hold;
`else
   assign shown = live;
`endif

   assign {MIN10, MIN1, SEC10, SEC1, CS10, CS1} = shown;
   assign RUNNING = running;
   assign OVF     = ovf;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd: expected outputs queued with each stimulus step, compared on the negedge after.
// Define STOPWATCH_LAP_EN to also cover the lap freeze.
module tb_stopwatch_bcd;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       EN10MS = 1'b0;
   logic       STARTSTOP = 1'b0;
   logic       CLR = 1'b0;
   logic [3:0] CS1, CS10, SEC1, SEC10, MIN1, MIN10;
   logic       RUNNING, OVF;
`ifdef STOPWATCH_LAP_EN
   logic       LAP = 1'b0;
   logic       LAPHOLD;
`endif

   int checks = 0;
   int passes = 0;

   typedef struct packed {
      logic [23:0] dig;
      logic        run;
      logic        ovf;
      logic        hold;
   } exp_t;

   exp_t  sb_q[$];
   string tag_q[$];

   always #5 CLK = ~CLK;

   stopwatch_bcd dut (
      .CLK(CLK),
      .RST(RST),
      .EN10MS(EN10MS),
      .STARTSTOP(STARTSTOP),
      .CLR(CLR),
`ifdef STOPWATCH_LAP_EN
      .LAP(LAP),
      .LAPHOLD(LAPHOLD),
`endif
      .CS1(CS1),
      .CS10(CS10),
      .SEC1(SEC1),
      .SEC10(SEC10),
      .MIN1(MIN1),
      .MIN10(MIN10),
      .RUNNING(RUNNING),
      .OVF(OVF)
   );

   task automatic expect_out(input string tag, input logic [23:0] d, input logic r,
                             input logic o, input logic h);
      exp_t e;
      e.dig  = d;
      e.run  = r;
      e.ovf  = o;
      e.hold = h;
      sb_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic check();
      exp_t        e;
      string       tag;
      logic [23:0] dig;
      e   = sb_q.pop_front();
      tag = tag_q.pop_front();
      dig = {MIN10, MIN1, SEC10, SEC1, CS10, CS1};
      checks++;
      assert (dig === e.dig) passes++;
      else $error("FAIL %s digits: got %h expected %h", tag, dig, e.dig);
      checks++;
      assert (RUNNING === e.run) passes++;
      else $error("FAIL %s RUNNING: got %b expected %b", tag, RUNNING, e.run);
      checks++;
      assert (OVF === e.ovf) passes++;
      else $error("FAIL %s OVF: got %b expected %b", tag, OVF, e.ovf);
`ifdef STOPWATCH_LAP_EN
      checks++;
      assert (LAPHOLD === e.hold) passes++;
      else $error("FAIL %s LAPHOLD: got %b expected %b", tag, LAPHOLD, e.hold);
`endif
   endtask

   // called at a negedge; one active cycle then one quiet cycle so the next press is a fresh edge
   task automatic step(input logic ss, input logic cl, input logic en);
      STARTSTOP = ss;
      CLR       = cl;
      EN10MS    = en;
      @(negedge CLK);
      STARTSTOP = 1'b0;
      CLR       = 1'b0;
      EN10MS    = 1'b0;
      @(negedge CLK);
   endtask

   task automatic ticks(input int n);
      EN10MS = 1'b1;
      repeat (n) @(negedge CLK);
      EN10MS = 1'b0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
   endtask

`ifdef STOPWATCH_LAP_EN
   task automatic lap_press();
      LAP = 1'b1;
      @(negedge CLK);
      LAP = 1'b0;
      @(negedge CLK);
   endtask
`endif

   initial begin
      @(negedge CLK);
      @(negedge CLK);

      // reset state
      expect_out("reset", 24'h000000, 1'b0, 1'b0, 1'b0);
      do_reset();
      check();

      // 150 ticks after start
      expect_out("run150", 24'h000150, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      ticks(150);
      check();

      // pause holds, resume continues
      do_reset();
      expect_out("pause47", 24'h000047, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      ticks(37);
      ticks(10);
      step(1'b1, 1'b0, 1'b0);
      ticks(5);
      check();
      expect_out("resume52", 24'h000052, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      ticks(5);
      check();

      // clear and start together in PAUSE: clear wins, then EN10MS ignored in IDLE
      step(1'b1, 1'b0, 1'b0);
      expect_out("clr_wins", 24'h000000, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      check();
      expect_out("idle_hold", 24'h000000, 1'b0, 1'b0, 1'b0);
      ticks(3);
      check();

      // start coincident with tick
      do_reset();
      expect_out("at09", 24'h000009, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      ticks(9);
      check();
      expect_out("ss_tick_run", 24'h000010, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      check();
      expect_out("ss_tick_pause", 24'h000010, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      check();
      expect_out("after_resume", 24'h000011, 1'b1, 1'b0, 1'b0);
      ticks(1);
      check();

      // clear ignored in RUN, then asynchronous reset mid-run
      do_reset();
      expect_out("at200", 24'h000200, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      ticks(200);
      check();
      expect_out("clr_in_run", 24'h000200, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check();
      expect_out("async_rst", 24'h000000, 1'b0, 1'b0, 1'b0);
      EN10MS = 1'b1;
      #2;
      RST = 1'b1;
      STARTSTOP = 1'b1;
      #1;
      check();
      @(negedge CLK);
      RST = 1'b0;
      repeat (3) @(negedge CLK);
      expect_out("held_btn", 24'h000000, 1'b0, 1'b0, 1'b0);
      check();
      STARTSTOP = 1'b0;
      @(negedge CLK);
      EN10MS = 1'b0;

      // cascade into minutes and wrap at 59:59.99
      do_reset();
      expect_out("at59_99s", 24'h005999, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      ticks(5999);
      check();
      expect_out("at1min", 24'h010000, 1'b1, 1'b0, 1'b0);
      ticks(1);
      check();
      expect_out("at_max", 24'h595999, 1'b1, 1'b0, 1'b0);
      ticks(353999);
      check();
      expect_out("wrap", 24'h000000, 1'b1, 1'b1, 1'b0);
      ticks(1);
      check();
      expect_out("after_wrap", 24'h000003, 1'b1, 1'b1, 1'b0);
      ticks(3);
      check();
      expect_out("ovf_pause", 24'h000003, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      check();
      expect_out("ovf_clr", 24'h000000, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check();

`ifdef STOPWATCH_LAP_EN
      do_reset();
      expect_out("lap_idle", 24'h000000, 1'b0, 1'b0, 1'b0);
      lap_press();
      check();
      expect_out("lap_at300", 24'h000300, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      ticks(300);
      check();
      expect_out("lap_frozen", 24'h000300, 1'b1, 1'b0, 1'b1);
      lap_press();
      ticks(200);
      check();
      expect_out("lap_release", 24'h000500, 1'b1, 1'b0, 1'b0);
      lap_press();
      check();
      expect_out("lap_again", 24'h000500, 1'b1, 1'b0, 1'b1);
      lap_press();
      ticks(7);
      check();
      expect_out("lap_clr", 24'h000000, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check();
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
